// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store bus sequencer.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [STRB_W-1:0] STRB_NONE = 4'b0000;
    localparam logic [STRB_W-1:0] STRB_BYTE = 4'b0001;
    localparam logic [STRB_W-1:0] STRB_HALF = 4'b0011;
    localparam logic [STRB_W-1:0] STRB_WORD = 4'b1111;

    // Unsigned widths exist only for loads.
    function automatic logic f3_supported(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store strobes/data replication, load extraction
// and extension, plus alignment and width legality checks.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        off_i,
    input  logic              is_store_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [DATA_W-1:0] rdata_ext_o,
    output logic              misaligned_o,
    output logic              illegal_o
);

    logic [DATA_W-1:0] byte_rep;
    logic [DATA_W-1:0] half_rep;
    logic [DATA_W-1:0] lane_shifted;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_byte_rep
            assign byte_rep[gi*8 +: 8] = wdata_i[7:0];
        end
        for (gi = 0; gi < STRB_W / 2; gi++) begin : g_half_rep
            assign half_rep[gi*16 +: 16] = wdata_i[15:0];
        end
    endgenerate

    assign lane_shifted = bus_rdata_i >> {off_i, 3'b000};
    assign byte_lane    = lane_shifted[7:0];
    assign half_lane    = lane_shifted[15:0];

    always_comb begin
        wstrb_o      = STRB_NONE;
        bus_wdata_o  = wdata_i;
        rdata_ext_o  = bus_rdata_i;
        misaligned_o = 1'b0;
        illegal_o    = !f3_supported(funct3_i, is_store_i);
        // funct3[2] selects zero extension for BU/HU.
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o     = STRB_BYTE << off_i;
                bus_wdata_o = byte_rep;
                rdata_ext_o = {{24{byte_lane[7] & ~funct3_i[2]}}, byte_lane};
            end
            2'b01: begin
                wstrb_o      = STRB_HALF << off_i;
                bus_wdata_o  = half_rep;
                misaligned_o = off_i[0];
                rdata_ext_o  = {{16{half_lane[15] & ~funct3_i[2]}}, half_lane};
            end
            2'b10: begin
                wstrb_o      = STRB_WORD;
                misaligned_o = |off_i;
            end
            default: ;
        endcase
        if (illegal_o) begin
            misaligned_o = 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: decodes the access, runs the req/gnt/rvalid handshake,
// stalls the core meanwhile and reports completion, illegal access or timeout.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata_out,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam logic             TMO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;

    logic              in_idle;
    logic [2:0]        f3_sel;
    logic [1:0]        off_sel;
    logic              store_sel;
    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              lane_misaligned;
    logic              lane_illegal;
    logic              legal;
    logic              start;
    logic              reject;
    logic [CNT_W-1:0]  cnt_inc;
    logic              tmo_hit;

    // One aligner serves both the decode in IDLE and the load capture later,
    // so it sees the live inputs only while idle and the latched copy otherwise.
    assign in_idle   = (state_q == S_IDLE);
    assign f3_sel    = in_idle ? funct3    : f3_q;
    assign off_sel   = in_idle ? addr[1:0] : off_q;
    assign store_sel = in_idle ? mem_write : we_q;

    mem_lane_align u_align (
        .funct3_i     (f3_sel),
        .off_i        (off_sel),
        .is_store_i   (store_sel),
        .wdata_i      (wdata),
        .bus_rdata_i  (bus_rdata),
        .wstrb_o      (lane_wstrb),
        .bus_wdata_o  (lane_wdata),
        .rdata_ext_o  (lane_rdata),
        .misaligned_o (lane_misaligned),
        .illegal_o    (lane_illegal)
    );

    assign legal   = (mem_read ^ mem_write) && !lane_illegal && !lane_misaligned;
    assign start   = in_idle && legal;
    assign reject  = in_idle && (mem_read | mem_write) && !legal;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign tmo_hit = TMO_EN && (cnt_inc == TMO_LIMIT);

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    we_d    = mem_write;
                    wstrb_d = mem_write ? lane_wstrb : STRB_NONE;
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    wdata_d = lane_wdata;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // A timeout wins over a late grant; rvalid here is ignored.
                if (tmo_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else if (bus_gnt) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_inc;
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = lane_rdata;
                    end
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            wstrb_q <= STRB_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // stall and err are gated by reset so a held request cannot leak through it.
    assign stall     = rst_n && (start || state_q == S_REQ || state_q == S_RESP);
    assign err       = rst_n && (reject || (state_q == S_DONE && tmo_q));
    assign done      = (state_q == S_DONE);
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-cycle comparison against a transaction-level
// model, directed accesses with literal expectations, and a short-timeout copy.
module tb_mem_access_ctrl;

    localparam int MT = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic        stall, done, err, bus_req, bus_we;
    logic [3:0]  bus_wstrb;

    logic        t_mem_read = 1'b0, t_mem_write = 1'b0;
    logic        t_bus_gnt = 1'b0, t_bus_rvalid = 1'b0;
    logic [31:0] t_rdata_out, t_bus_addr, t_bus_wdata;
    logic        t_stall, t_done, t_err, t_bus_req, t_bus_we;
    logic [3:0]  t_bus_wstrb;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(MT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata_out(rdata_out),
        .stall(stall), .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(8)) dut_t (
        .clk(clk), .rst_n(rst_n), .mem_read(t_mem_read), .mem_write(t_mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata_out(t_rdata_out),
        .stall(t_stall), .done(t_done), .err(t_err), .bus_req(t_bus_req), .bus_we(t_bus_we),
        .bus_addr(t_bus_addr), .bus_wstrb(t_bus_wstrb), .bus_wdata(t_bus_wdata),
        .bus_gnt(t_bus_gnt), .bus_rvalid(t_bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        if (rd == wr) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
        int unsigned nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return 32'(wd[7:0]) * 32'h01010101;
        if (f3[1:0] == 2'd1) return 32'(wd[15:0]) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (f3[1:0] == 2'd0) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (f3[1:0] == 2'd1) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    bit          m_busy, m_granted, m_done_pend, m_err_pend, m_store;
    int          m_age;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wd, m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_granted <= 0; m_done_pend <= 0; m_err_pend <= 0;
            m_store <= 0; m_age <= 0; m_f3 <= '0; m_addr <= '0; m_wd <= '0; m_rdata <= '0;
        end else if (m_done_pend) begin
            m_done_pend <= 0;
            m_err_pend  <= 0;
        end else if (m_busy) begin
            m_age <= m_age + 1;
            if (!m_granted && MT != 0 && m_age + 1 == MT) begin
                m_busy <= 0; m_done_pend <= 1; m_err_pend <= 1;
            end else if (!m_granted) begin
                if (bus_gnt) m_granted <= 1;
            end else if (bus_rvalid) begin
                m_busy <= 0; m_done_pend <= 1;
                if (!m_store) m_rdata <= m_load(m_f3, m_addr[1:0], bus_rdata);
            end else if (MT != 0 && m_age + 1 == MT) begin
                m_busy <= 0; m_done_pend <= 1; m_err_pend <= 1;
            end
        end else if (m_legal(mem_read, mem_write, funct3, addr)) begin
            m_busy <= 1; m_granted <= 0; m_age <= 0;
            m_store <= mem_write; m_f3 <= funct3; m_addr <= addr; m_wd <= wdata;
        end
    end

    initial begin : compare
        logic e_stall, e_req, e_done, e_err;
        forever begin
            @(negedge clk);
            #2;
            e_stall = 0; e_req = 0; e_done = 0; e_err = 0;
            if (!rst_n) begin
                check("rst_bus_addr", bus_addr, 32'h0);
                check("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
                check("rst_bus_wdata", bus_wdata, 32'h0);
                check("rst_bus_we", 32'(bus_we), 32'h0);
            end else if (m_done_pend) begin
                e_done = 1; e_err = m_err_pend;
            end else if (m_busy) begin
                e_stall = 1; e_req = !m_granted;
            end else begin
                e_stall = m_legal(mem_read, mem_write, funct3, addr);
                e_err   = (mem_read | mem_write) && !e_stall;
            end
            check("cyc_stall", 32'(stall), 32'(e_stall));
            check("cyc_bus_req", 32'(bus_req), 32'(e_req));
            check("cyc_done", 32'(done), 32'(e_done));
            check("cyc_err", 32'(err), 32'(e_err));
            check("cyc_rdata_out", rdata_out, m_rdata);
            if (rst_n && m_busy && !m_granted) begin
                check("cyc_bus_addr", bus_addr, m_addr & 32'hFFFFFFFC);
                check("cyc_bus_we", 32'(bus_we), 32'(m_store));
                check("cyc_bus_wstrb", 32'(bus_wstrb), m_store ? 32'(m_strb(m_f3, m_addr[1:0])) : 32'h0);
                if (m_store) check("cyc_bus_wdata", bus_wdata, m_wdata(m_f3, m_wd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gnt_wait, input int rv_delay, input logic [31:0] rdat,
                              output int n_stall, output int n_req, output int n_done,
                              output logic [31:0] s_addr, output logic [31:0] s_wdata,
                              output logic [3:0] s_wstrb, output logic s_we);
        int  g_cyc;
        bit  granted;
        bit  finished;
        n_stall = 0; n_req = 0; n_done = 0; g_cyc = 0; granted = 0; finished = 0;
        s_addr = '0; s_wdata = '0; s_wstrb = '0; s_we = 1'b0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int c = 0; c < 40 && !finished; c++) begin
            #1;
            bus_gnt = 0; bus_rvalid = 0;
            n_stall += int'(stall);
            if (done) begin
                n_done++;
                finished = 1;
            end
            if (bus_req) begin
                s_addr = bus_addr; s_wdata = bus_wdata; s_wstrb = bus_wstrb; s_we = bus_we;
                if (n_req == gnt_wait) begin
                    bus_gnt = 1; granted = 1; g_cyc = c;
                end
                n_req++;
            end else if (granted && c == g_cyc + rv_delay) begin
                bus_rvalid = 1; bus_rdata = rdat;
            end
            @(negedge clk);
        end
        mem_read = 0; mem_write = 0; bus_gnt = 0; bus_rvalid = 0;
    endtask

    task automatic illegal_access(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input string nm);
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
        #1;
        check({nm, "_err"}, 32'(err), 32'h1);
        check({nm, "_stall"}, 32'(stall), 32'h0);
        check({nm, "_req"}, 32'(bus_req), 32'h0);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        #1;
        check({nm, "_err_clear"}, 32'(err), 32'h0);
        check({nm, "_req_after"}, 32'(bus_req), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n_stall, n_req, n_done, k;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        logic        s_we;

        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_req", 32'(bus_req), 32'h0);
        check("reset_rdata", rdata_out, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // LW, grant immediately, response two cycles after the grant
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("lw_done", 32'(n_done), 32'd1);
        check("lw_stall_cycles", 32'(n_stall), 32'd4);
        check("lw_bus_addr", s_addr, 32'h100);
        check("lw_wstrb", 32'(s_wstrb), 32'h0);
        check("lw_we", 32'(s_we), 32'h0);
        check("lw_rdata", rdata_out, 32'hDEADBEEF);

        run_access(1, 0, 3'b000, 32'h203, 32'h0, 0, 1, 32'h80123456,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("lb_done", 32'(n_done), 32'd1);
        check("lb_bus_addr", s_addr, 32'h200);
        check("lb_rdata", rdata_out, 32'hFFFFFF80);
        run_access(1, 0, 3'b100, 32'h203, 32'h0, 0, 1, 32'h80123456,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("lbu_rdata", rdata_out, 32'h00000080);

        // SH to upper half, grant withheld for three cycles
        run_access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 3, 1, 32'h0,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("sh_done", 32'(n_done), 32'd1);
        check("sh_req_cycles", 32'(n_req), 32'd4);
        check("sh_wdata", s_wdata, 32'hABCDABCD);
        check("sh_wstrb", 32'(s_wstrb), 32'hC);
        check("sh_we", 32'(s_we), 32'h1);
        check("sh_rdata_kept", rdata_out, 32'h00000080);

        run_access(0, 1, 3'b000, 32'h101, 32'h1234565A, 1, 2, 32'h0,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("sb_wdata", s_wdata, 32'h5A5A5A5A);
        check("sb_wstrb", 32'(s_wstrb), 32'h2);
        run_access(1, 0, 3'b001, 32'h202, 32'h0, 0, 1, 32'h80011234,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("lh_rdata", rdata_out, 32'hFFFF8001);
        run_access(1, 0, 3'b101, 32'h202, 32'h0, 0, 1, 32'h80011234,
                   n_stall, n_req, n_done, s_addr, s_wdata, s_wstrb, s_we);
        check("lhu_rdata", rdata_out, 32'h00008001);

        illegal_access(1, 0, 3'b010, 32'h101, "lw_misaligned");
        illegal_access(0, 1, 3'b011, 32'h100, "sw_bad_f3");
        illegal_access(1, 1, 3'b010, 32'h100, "rd_and_wr");
        illegal_access(0, 1, 3'b001, 32'h103, "sh_misaligned");

        // Short-timeout instance: one good load, then a store that never gets rvalid
        @(negedge clk);
        t_mem_read = 1; funct3 = 3'b010; addr = 32'h40; bus_rdata = 32'h12345678;
        @(negedge clk); #1;
        check("t_req", 32'(t_bus_req), 32'h1);
        t_bus_gnt = 1;
        @(negedge clk); #1;
        t_bus_gnt = 0; t_bus_rvalid = 1;
        @(negedge clk); #1;
        t_bus_rvalid = 0;
        check("t_load_done", 32'(t_done), 32'h1);
        check("t_load_rdata", t_rdata_out, 32'h12345678);
        @(negedge clk);
        t_mem_read = 0; t_mem_write = 1; addr = 32'h44; wdata = 32'h11223344;
        @(negedge clk); #1;
        check("t_sw_req", 32'(t_bus_req), 32'h1);
        check("t_sw_addr", t_bus_addr, 32'h44);
        check("t_sw_we", 32'(t_bus_we), 32'h1);
        check("t_sw_wstrb", 32'(t_bus_wstrb), 32'hF);
        check("t_sw_wdata", t_bus_wdata, 32'h11223344);
        t_bus_gnt = 1;
        k = -1;
        for (int c = 1; c < 20 && k < 0; c++) begin
            @(negedge clk); #1;
            t_bus_gnt = 0;
            if (t_done) k = c;
            else check("t_wait_stall", 32'(t_stall), 32'h1);
        end
        check("t_timeout_cycles", 32'(k), 32'd4);
        check("t_timeout_err", 32'(t_err), 32'h1);
        check("t_timeout_done", 32'(t_done), 32'h1);
        check("t_timeout_stall", 32'(t_stall), 32'h0);
        check("t_timeout_rdata", t_rdata_out, 32'h12345678);
        @(negedge clk);
        t_mem_write = 0;
        #1;
        check("t_after_done", 32'(t_done), 32'h0);
        check("t_after_err", 32'(t_err), 32'h0);

        // Reset in the middle of a response wait, then a stray rvalid
        @(negedge clk);
        mem_read = 1; funct3 = 3'b010; addr = 32'h300;
        @(negedge clk); #1;
        check("rst_mid_req", 32'(bus_req), 32'h1);
        bus_gnt = 1;
        @(negedge clk); #1;
        bus_gnt = 0;
        check("rst_mid_stall", 32'(stall), 32'h1);
        rst_n = 0;
        #1;
        check("rst_mid_stall_low", 32'(stall), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_req_low", 32'(bus_req), 32'h0);
        check("rst_mid_addr", bus_addr, 32'h0);
        check("rst_mid_rdata", rdata_out, 32'h0);
        @(negedge clk);
        rst_n = 1; mem_read = 0; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            bus_rvalid = 0;
            check("late_rvalid_done", 32'(done), 32'h0);
            check("late_rvalid_rdata", rdata_out, 32'h0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
